// File: rtl/compare_serial_acc.sv
// Serial word comparator: folds MSB-first per-digit lt/gt/eq flags into one
// whole-word result, presented with a valid/ready handshake.
module compare_serial_acc #(
  parameter int MAX_DIGITS = 8,
  parameter int CNT_W      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_last,
  input  logic             lt_in,
  input  logic             gt_in,
  input  logic             eq_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_lt,
  output logic             out_gt,
  output logic             out_eq,
  output logic             out_err,
  output logic [CNT_W-1:0] out_digits
);

  typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_DIGITS);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic             r_dec_lt;
  logic             r_dec_gt;
  logic             r_err;
  logic             r_out_valid;
  logic             r_out_lt;
  logic             r_out_gt;
  logic             r_out_eq;
  logic             r_out_err;
  logic [CNT_W-1:0] r_out_digits;

  logic             w_acc;
  logic             w_onehot;
  logic             w_dec_free;
  logic             w_dec_lt_nxt;
  logic             w_dec_gt_nxt;
  logic             w_err_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_close;
  logic             w_hshk;

  assign in_ready = (r_state != HOLD);
  assign w_acc    = in_valid && in_ready;
  assign w_hshk   = r_out_valid && out_ready;

  assign w_onehot = ( lt_in & ~gt_in & ~eq_in) |
                    (~lt_in &  gt_in & ~eq_in) |
                    (~lt_in & ~gt_in &  eq_in);

  // Only the first well-formed deciding digit may set the decision; it then sticks.
  assign w_dec_free   = ~r_dec_lt & ~r_dec_gt;
  assign w_dec_lt_nxt = r_dec_lt | (w_dec_free & w_onehot & lt_in);
  assign w_dec_gt_nxt = r_dec_gt | (w_dec_free & w_onehot & gt_in);
  assign w_err_nxt    = r_err | ~w_onehot;
  assign w_cnt_nxt    = r_cnt + CNT_W'(1);
  assign w_close      = w_acc && (in_last || (w_cnt_nxt == MAX_CNT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (w_acc) w_state_nxt = w_close ? HOLD : ACC;
      ACC:  if (w_close) w_state_nxt = HOLD;
      HOLD: if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt        <= '0;
      r_dec_lt     <= 1'b0;
      r_dec_gt     <= 1'b0;
      r_err        <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_lt     <= 1'b0;
      r_out_gt     <= 1'b0;
      r_out_eq     <= 1'b0;
      r_out_err    <= 1'b0;
      r_out_digits <= '0;
    end else if (w_hshk) begin
      r_cnt        <= '0;
      r_dec_lt     <= 1'b0;
      r_dec_gt     <= 1'b0;
      r_err        <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_lt     <= 1'b0;
      r_out_gt     <= 1'b0;
      r_out_eq     <= 1'b0;
      r_out_err    <= 1'b0;
      r_out_digits <= '0;
    end else if (w_acc) begin
      r_cnt    <= w_cnt_nxt;
      r_dec_lt <= w_dec_lt_nxt;
      r_dec_gt <= w_dec_gt_nxt;
      r_err    <= w_err_nxt;
      // An erroneous word reports no ordering at all, only out_err.
      if (w_close) begin
        r_out_valid  <= 1'b1;
        r_out_lt     <= ~w_err_nxt & w_dec_lt_nxt;
        r_out_gt     <= ~w_err_nxt & w_dec_gt_nxt;
        r_out_eq     <= ~w_err_nxt & ~w_dec_lt_nxt & ~w_dec_gt_nxt;
        r_out_err    <= w_err_nxt;
        r_out_digits <= w_cnt_nxt;
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign out_lt     = r_out_lt;
  assign out_gt     = r_out_gt;
  assign out_eq     = r_out_eq;
  assign out_err    = r_out_err;
  assign out_digits = r_out_digits;

endmodule

// File: tb/tb_compare_serial_acc.sv
// Scoreboard bench for compare_serial_acc: a digit-level model pushes expected
// word results; a negedge monitor pops and compares them as they appear.
module tb_compare_serial_acc;

  localparam int MAX_DIGITS = 8;
  localparam int CNT_W      = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic             in_last;
  logic             lt_in;
  logic             gt_in;
  logic             eq_in;
  logic             out_valid;
  logic             out_ready;
  logic             out_lt;
  logic             out_gt;
  logic             out_eq;
  logic             out_err;
  logic [CNT_W-1:0] out_digits;

  compare_serial_acc #(.MAX_DIGITS(MAX_DIGITS), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .lt_in(lt_in), .gt_in(gt_in), .eq_in(eq_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_lt(out_lt), .out_gt(out_gt), .out_eq(out_eq), .out_err(out_err),
    .out_digits(out_digits)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       lt;
    logic       gt;
    logic       eq;
    logic       err;
    logic [3:0] digits;
    int         cyc;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_push  = 0;
  int   n_res   = 0;
  int   cyc     = 0;

  int m_cnt = 0;
  int m_dec = 0;
  bit m_err = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_cnt = 0;
    m_dec = 0;
    m_err = 1'b0;
  endtask

  // Called at a negedge with a digit driven; returns once the digit will be taken.
  task automatic wait_acc();
    exp_t e;
    int   n;
    bit   mal;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      check_eq("accept_timeout", 1, 0);
      return;
    end
    mal = (int'(lt_in) + int'(gt_in) + int'(eq_in)) != 1;
    m_cnt++;
    if (!mal && m_dec == 0 && (lt_in || gt_in)) m_dec = lt_in ? 1 : 2;
    if (mal) m_err = 1'b1;
    if (in_last || m_cnt == MAX_DIGITS) begin
      e.lt     = !m_err && m_dec == 1;
      e.gt     = !m_err && m_dec == 2;
      e.eq     = !m_err && m_dec == 0;
      e.err    = m_err;
      e.digits = 4'(m_cnt);
      e.cyc    = cyc + 1;
      q.push_back(e);
      n_push++;
      model_clear();
    end
  endtask

  task automatic send(input logic lt, input logic gt, input logic eq, input logic last);
    @(negedge clk);
    in_valid = 1'b1;
    lt_in    = lt;
    gt_in    = gt;
    eq_in    = eq;
    in_last  = last;
    wait_acc();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      {lt_in, gt_in, eq_in, in_last} = 4'($urandom_range(0, 15));
    end
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check_eq("valid_timeout", 0, 1);
  endtask

  // Monitor: pop on first appearance of a result, then demand it stays put.
  bit          seen = 1'b0;
  logic [7:0]  held;
  always @(negedge clk) begin
    exp_t e;
    if (out_valid) begin
      if (!seen) begin
        seen = 1'b1;
        held = {out_lt, out_gt, out_eq, out_err, out_digits};
        if (q.size() == 0) begin
          check_eq("unexpected_result", 1, 0);
        end else begin
          e = q.pop_front();
          n_res++;
          check_eq("out_lt", out_lt, e.lt);
          check_eq("out_gt", out_gt, e.gt);
          check_eq("out_eq", out_eq, e.eq);
          check_eq("out_err", out_err, e.err);
          check_eq("out_digits", out_digits, e.digits);
          check_eq("latency", cyc, e.cyc);
        end
      end else begin
        check_eq("hold_stable", {out_lt, out_gt, out_eq, out_err, out_digits}, held);
      end
    end else begin
      seen = 1'b0;
      check_eq("idle_zero", {out_lt, out_gt, out_eq, out_err}, 4'b0);
    end
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    lt_in     = 1'b0;
    gt_in     = 1'b0;
    eq_in     = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_digits", out_digits, 0);
    check_eq("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;

    // eq,eq,gt,lt -> GT decided by the third digit
    send(0, 0, 1, 0);
    send(0, 0, 1, 0);
    send(0, 1, 0, 0);
    send(1, 0, 0, 1);
    idle(3);

    // all-eq word held under back-pressure
    out_ready = 1'b0;
    send(0, 0, 1, 0);
    send(0, 0, 1, 0);
    send(0, 0, 1, 1);
    idle(1);
    wait_valid();
    repeat (5) begin
      check_eq("bp_in_ready", in_ready, 0);
      check_eq("bp_out_valid", out_valid, 1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    idle(3);

    // malformed second digit
    send(1, 0, 0, 0);
    send(0, 1, 1, 1);
    idle(3);

    // forced close at MAX_DIGITS, ninth digit must wait for the handshake
    out_ready = 1'b0;
    for (int i = 0; i < MAX_DIGITS; i++) send(0, 0, 1, 0);
    @(negedge clk);
    in_valid = 1'b1;
    {lt_in, gt_in, eq_in, in_last} = 4'b0011;
    repeat (3) begin
      check_eq("max_in_ready", in_ready, 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    check_eq("hshk_in_ready", in_ready, 0);
    wait_acc();
    idle(3);

    // reset mid-word discards it
    send(0, 0, 1, 0);
    send(0, 1, 0, 0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    check_eq("mid_rst_valid", out_valid, 0);
    check_eq("mid_rst_ready", in_ready, 1);
    check_eq("mid_rst_digits", out_digits, 0);
    rst_n = 1'b1;
    send(1, 0, 0, 1);
    idle(3);

    // gt,lt,lt with random gaps
    for (int r = 0; r < 4; r++) begin
      idle($urandom_range(0, 3));
      send(0, 1, 0, 0);
      idle($urandom_range(0, 3));
      send(1, 0, 0, 0);
      idle($urandom_range(0, 3));
      send(1, 0, 0, 1);
      idle(1);
    end

    begin
      int n;
      n = 0;
      while ((q.size() != 0 || out_valid) && n < 50) begin
        @(negedge clk);
        n++;
      end
    end
    idle(2);
    check_eq("queue_drained", q.size(), 0);
    check_eq("result_count", n_res, n_push);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
